// File: rtl/q_wall_masker.sv
// q_wall_masker
//   Walks a small list of blocked maze cells and issues Q-table writes that
//   overwrite every action leading into each blocked cell (and, optionally,
//   every action leaving it) with a fixed mask value.
//
//   Ports
//     clk, rst                 clock, asynchronous active-high reset
//     blk_valid/row/col        push one blocked cell into the list
//     blk_ready                list accepts a push this cycle (IDLE, not full)
//     blk_err                  one-cycle pulse after an out-of-range push
//     clear_list               empty the list (IDLE only, wins over a push)
//     start                    begin a masking job (IDLE only)
//     mask_self, mask_value    job options, sampled with start
//     busy, done               job in progress / one-cycle completion pulse
//     q_we/q_state/q_action/q_wdata, q_wr_ready
//                              Q-table write port with back-pressure
//     blk_count                current list occupancy
module q_wall_masker #(
   parameter  int ROWS    = 6,
   parameter  int COLS    = 6,
   parameter  int QW      = 32,
   parameter  int MAX_BLK = 16,
   localparam int SW      = $clog2(ROWS*COLS+1),
   localparam int RW      = (ROWS > 1) ? $clog2(ROWS) : 1,
   localparam int CW      = (COLS > 1) ? $clog2(COLS) : 1,
   localparam int BCW     = $clog2(MAX_BLK+1)
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           blk_valid,
   input  logic [RW-1:0]  blk_row,
   input  logic [CW-1:0]  blk_col,
   output logic           blk_ready,
   output logic           blk_err,
   input  logic           clear_list,
   input  logic           start,
   input  logic           mask_self,
   input  logic [QW-1:0]  mask_value,
   output logic           busy,
   output logic           done,
   output logic           q_we,
   output logic [SW-1:0]  q_state,
   output logic [1:0]     q_action,
   output logic [QW-1:0]  q_wdata,
   input  logic           q_wr_ready,
   output logic [BCW-1:0] blk_count
);

   localparam int IW = (MAX_BLK > 1) ? $clog2(MAX_BLK) : 1;
   localparam logic [RW:0] ROWS_L = (RW+1)'(ROWS);
   localparam logic [CW:0] COLS_L = (CW+1)'(COLS);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SCAN,
      S_EMIT,
      S_DONE
   } state_t;

   state_t state_q, state_d;

   // list storage; contents need no reset, occupancy alone defines validity
   logic [RW-1:0]  row_mem [MAX_BLK];
   logic [CW-1:0]  col_mem [MAX_BLK];
   logic [BCW-1:0] count_q;

   // job context
   logic [IW-1:0]  idx_q;
   logic [SW-1:0]  b_q;
   logic [RW-1:0]  r_q;
   logic [CW-1:0]  c_q;
   logic [2:0]     slot_q;
   logic           self_q;
   logic [QW-1:0]  wdata_q;
   logic           err_q;

   logic           in_range;
   logic           push_acc;
   logic           store;
   logic [BCW-1:0] count_after;
   logic [SW-1:0]  b_calc;
   logic           slot_ok;
   logic [SW-1:0]  slot_tgt;
   logic           last_slot;
   logic           adv;
   logic           more;

   // ------------------------------------------------------------------
   // list push / clear
   // ------------------------------------------------------------------
   assign blk_ready = (state_q == S_IDLE) && (count_q < BCW'(MAX_BLK));
   assign in_range  = ({1'b0, blk_row} < ROWS_L) && ({1'b0, blk_col} < COLS_L);
   assign push_acc  = blk_valid && blk_ready;
   assign store     = push_acc && in_range && !clear_list;

   // occupancy as seen at the end of this cycle, so a start issued together
   // with a push already includes the pushed entry
   always_comb begin
      count_after = count_q;
      if (clear_list)
         count_after = '0;
      else if (store)
         count_after = count_q + BCW'(1);
   end

   always_ff @(posedge clk) begin
      if (store) begin
         row_mem[count_q[IW-1:0]] <= blk_row;
         col_mem[count_q[IW-1:0]] <= blk_col;
      end
   end

   // ------------------------------------------------------------------
   // slot decode for the current blocked cell b = r*COLS + c + 1
   // ------------------------------------------------------------------
   assign b_calc = SW'(row_mem[idx_q]) * SW'(COLS) + SW'(col_mem[idx_q]) + SW'(1);

   always_comb begin
      slot_ok  = 1'b1;
      slot_tgt = b_q;
      case (slot_q)
         3'd0: begin
            slot_ok  = (r_q != '0);
            slot_tgt = b_q - SW'(COLS);
         end
         3'd1: begin
            slot_ok  = (c_q != '0);
            slot_tgt = b_q - SW'(1);
         end
         3'd2: begin
            slot_ok  = (r_q != RW'(ROWS-1));
            slot_tgt = b_q + SW'(COLS);
         end
         3'd3: begin
            slot_ok  = (c_q != CW'(COLS-1));
            slot_tgt = b_q + SW'(1);
         end
         default: begin
            // self slots 4..7, only reached when mask_self was latched
            slot_ok  = 1'b1;
            slot_tgt = b_q;
         end
      endcase
   end

   assign last_slot = self_q ? (slot_q == 3'd7) : (slot_q == 3'd3);
   // an off-grid slot burns its cycle without waiting on the memory
   assign adv       = !slot_ok || q_wr_ready;
   assign more      = (BCW'(idx_q) + BCW'(1)) < count_q;

   // ------------------------------------------------------------------
   // FSM
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state_q <= S_IDLE;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (start)
               state_d = (count_after != '0) ? S_SCAN : S_DONE;
         end
         S_SCAN: state_d = S_EMIT;
         S_EMIT: begin
            if (adv && last_slot)
               state_d = more ? S_SCAN : S_DONE;
         end
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // ------------------------------------------------------------------
   // datapath registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
         err_q   <= 1'b0;
         idx_q   <= '0;
         b_q     <= '0;
         r_q     <= '0;
         c_q     <= '0;
         slot_q  <= '0;
         self_q  <= 1'b0;
         wdata_q <= '0;
      end else begin
         err_q <= push_acc && !in_range;
         case (state_q)
            S_IDLE: begin
               count_q <= count_after;
               if (start) begin
                  self_q  <= mask_self;
                  wdata_q <= mask_value;
                  idx_q   <= '0;
               end
            end
            S_SCAN: begin
               b_q    <= b_calc;
               r_q    <= row_mem[idx_q];
               c_q    <= col_mem[idx_q];
               slot_q <= '0;
            end
            S_EMIT: begin
               if (adv) begin
                  if (last_slot)
                     idx_q <= idx_q + IW'(1);
                  else
                     slot_q <= slot_q + 3'd1;
               end
            end
            default: ;
         endcase
      end
   end

   // ------------------------------------------------------------------
   // outputs
   // ------------------------------------------------------------------
   assign q_we      = (state_q == S_EMIT) && slot_ok;
   assign q_state   = q_we ? slot_tgt : '0;
   assign q_action  = q_we ? slot_q[1:0] : 2'd0;
   assign q_wdata   = wdata_q;
   assign busy      = (state_q == S_SCAN) || (state_q == S_EMIT);
   assign done      = (state_q == S_DONE);
   assign blk_err   = err_q;
   assign blk_count = count_q;

endmodule

// File: tb/tb_q_wall_masker.sv
module tb_q_wall_masker;

   localparam int ROWS    = 6;
   localparam int COLS    = 6;
   localparam int QW      = 32;
   localparam int MAX_BLK = 16;
   localparam int SW      = 6;
   localparam int RW      = 3;
   localparam int CW      = 3;
   localparam int BCW     = 5;
   localparam int EW      = SW + 2 + QW;

   logic           clk = 1'b0;
   logic           rst;
   logic           blk_valid;
   logic [RW-1:0]  blk_row;
   logic [CW-1:0]  blk_col;
   logic           blk_ready;
   logic           blk_err;
   logic           clear_list;
   logic           start;
   logic           mask_self;
   logic [QW-1:0]  mask_value;
   logic           busy;
   logic           done;
   logic           q_we;
   logic [SW-1:0]  q_state;
   logic [1:0]     q_action;
   logic [QW-1:0]  q_wdata;
   logic           q_wr_ready;
   logic [BCW-1:0] blk_count;

   q_wall_masker #(
      .ROWS(ROWS),
      .COLS(COLS),
      .QW(QW),
      .MAX_BLK(MAX_BLK)
   ) dut (
      .clk(clk),
      .rst(rst),
      .blk_valid(blk_valid),
      .blk_row(blk_row),
      .blk_col(blk_col),
      .blk_ready(blk_ready),
      .blk_err(blk_err),
      .clear_list(clear_list),
      .start(start),
      .mask_self(mask_self),
      .mask_value(mask_value),
      .busy(busy),
      .done(done),
      .q_we(q_we),
      .q_state(q_state),
      .q_action(q_action),
      .q_wdata(q_wdata),
      .q_wr_ready(q_wr_ready),
      .blk_count(blk_count)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int compared   = 0;
   int mismatched = 0;
   int t0         = 0;
   logic [QW-1:0] cur_wd = '0;
   logic [EW-1:0] expq [$];
   logic [EW-1:0] got_w, want_w;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      compared++;
      if (act !== req) begin
         mismatched++;
         $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // scoreboard monitor: every accepted write is matched against the queue
   always @(negedge clk) begin
      if (!rst && q_we && q_wr_ready) begin
         got_w = {q_state, q_action, q_wdata};
         if (expq.size() == 0) begin
            compared++;
            mismatched++;
            $display("FAIL unexpected_write: got %0h, want none", got_w);
         end else begin
            want_w = expq.pop_front();
            check("q_write", {24'd0, got_w}, {24'd0, want_w});
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expw(input int s, input int a);
      expq.push_back({SW'(s), 2'(a), cur_wd});
   endtask

   task automatic push(input int r, input int c);
      blk_valid = 1'b1;
      blk_row   = RW'(r);
      blk_col   = CW'(c);
      tick();
      blk_valid = 1'b0;
   endtask

   task automatic clear();
      clear_list = 1'b1;
      tick();
      clear_list = 1'b0;
   endtask

   task automatic start_job();
      mask_value = cur_wd;
      start      = 1'b1;
      tick();
      start      = 1'b0;
      t0         = cyc - 1;
   endtask

   task automatic wait_done(input string name, input int want);
      forever begin
         @(negedge clk);
         if (done || (cyc - t0) > 300) break;
      end
      check(name, 64'(cyc - t0), 64'(want));
      check("writes_left", 64'(expq.size()), 64'd0);
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst        = 1'b1;
      blk_valid  = 1'b0;
      blk_row    = '0;
      blk_col    = '0;
      clear_list = 1'b0;
      start      = 1'b0;
      mask_self  = 1'b0;
      mask_value = '0;
      q_wr_ready = 1'b1;
      #22;
      rst = 1'b0;
      tick();

      // reset state
      check("rst_blk_ready", 64'(blk_ready), 64'd1);
      check("rst_busy",      64'(busy),      64'd0);
      check("rst_done",      64'(done),      64'd0);
      check("rst_q_we",      64'(q_we),      64'd0);
      check("rst_count",     64'(blk_count), 64'd0);
      check("rst_err",       64'(blk_err),   64'd0);

      // single cell (1,2), b=9
      cur_wd = 32'h0;
      push(1, 2);
      check("count_1", 64'(blk_count), 64'd1);
      expw(3, 0); expw(8, 1); expw(15, 2); expw(10, 3);
      start_job();
      @(negedge clk);
      check("busy_scan", 64'(busy), 64'd1);
      wait_done("done_single", 6);

      // list retained, rerun with new value
      cur_wd = 32'h5;
      expw(3, 0); expw(8, 1); expw(15, 2); expw(10, 3);
      start_job();
      wait_done("done_rerun", 6);
      check("count_kept", 64'(blk_count), 64'd1);
      check("busy_idle", 64'(busy), 64'd0);

      // corners (0,0) b=1 and (5,5) b=36
      cur_wd = 32'hA5;
      clear();
      push(0, 0);
      push(5, 5);
      expw(7, 2); expw(2, 3); expw(30, 0); expw(35, 1);
      start_job();
      wait_done("done_corners", 11);

      // mask_self on (2,2) b=15
      cur_wd = 32'hFFFF_FFFF;
      clear();
      push(2, 2);
      expw(9, 0); expw(14, 1); expw(21, 2); expw(16, 3);
      expw(15, 0); expw(15, 1); expw(15, 2); expw(15, 3);
      mask_self = 1'b1;
      start_job();
      mask_self = 1'b0;
      wait_done("done_self", 10);

      // back-pressure: first write stalled for 3 cycles
      cur_wd = 32'h1234;
      clear();
      push(1, 2);
      expw(3, 0); expw(8, 1); expw(15, 2); expw(10, 3);
      q_wr_ready = 1'b0;
      start_job();
      tick();
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("stall_we",     64'(q_we),     64'd1);
         check("stall_state",  64'(q_state),  64'd3);
         check("stall_action", 64'(q_action), 64'd0);
         check("stall_wdata",  64'(q_wdata),  64'h1234);
         tick();
      end
      q_wr_ready = 1'b1;
      wait_done("done_stall", 9);

      // push and start in the same cycle: (3,4) b=23
      cur_wd = 32'h77;
      clear();
      expw(17, 0); expw(22, 1); expw(29, 2); expw(24, 3);
      mask_value = cur_wd;
      blk_valid  = 1'b1;
      blk_row    = 3'd3;
      blk_col    = 3'd4;
      start      = 1'b1;
      tick();
      blk_valid  = 1'b0;
      start      = 1'b0;
      t0         = cyc - 1;
      wait_done("done_push_start", 6);

      // full list
      clear();
      for (int i = 0; i < 16; i++) push(0, 1);
      check("full_count", 64'(blk_count), 64'd16);
      check("full_ready", 64'(blk_ready), 64'd0);
      push(0, 1);
      check("full_17th", 64'(blk_count), 64'd16);

      // out-of-range push and clear priority
      clear();
      check("clear_count", 64'(blk_count), 64'd0);
      push(0, 0);
      push(6, 0);
      check("err_pulse", 64'(blk_err),   64'd1);
      check("err_count", 64'(blk_count), 64'd1);
      tick();
      check("err_gone",  64'(blk_err),   64'd0);
      clear_list = 1'b1;
      blk_valid  = 1'b1;
      blk_row    = 3'd1;
      blk_col    = 3'd1;
      tick();
      clear_list = 1'b0;
      blk_valid  = 1'b0;
      check("clear_wins", 64'(blk_count), 64'd0);

      // reset during a stalled write
      push(1, 2);
      q_wr_ready = 1'b0;
      start_job();
      tick();
      @(negedge clk);
      check("pre_rst_we", 64'(q_we), 64'd1);
      #2;
      rst = 1'b1;
      #1;
      check("arst_we",     64'(q_we),      64'd0);
      check("arst_state",  64'(q_state),   64'd0);
      check("arst_action", 64'(q_action),  64'd0);
      check("arst_wdata",  64'(q_wdata),   64'd0);
      check("arst_busy",   64'(busy),      64'd0);
      check("arst_count",  64'(blk_count), 64'd0);
      tick();
      rst        = 1'b0;
      q_wr_ready = 1'b1;
      @(negedge clk);
      check("post_rst_ready", 64'(blk_ready), 64'd1);
      tick();
      start_job();
      wait_done("done_empty", 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
